// File: rtl/systolic_feeder.sv
// Edge feeder for an NxN systolic array: stores weight tile A and data tile B, then streams them
// with diagonal skew under compute_en. Optional tile counter: define SYSTOLIC_FEEDER_TILE_CNT_EN.
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 4,
    parameter int AW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [AW-1:0]   wr_row,
    input  logic [AW-1:0]   wr_col,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    output logic            busy,
    output logic            load_err,
    output logic            compute_en,
    output logic [N*DW-1:0] weight_out,
    output logic [N*DW-1:0] data_out,
    output logic            result_valid
`ifdef SYSTOLIC_FEEDER_TILE_CNT_EN
    ,
    output logic [7:0]      tile_count
`endif
);

    localparam int TW = $clog2(3*N);
    localparam logic [TW-1:0] T_LAST = TW'(3*N-3);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [TW-1:0] step;
    logic [TW-1:0] step_next;
    logic          is_idle;
    logic          launch;
    logic          fwd_a;
    logic          fwd_b;
    logic [N*DW-1:0] w_next;
    logic [N*DW-1:0] d_next;

    logic [DW-1:0] a_mem [N][N];
    logic [DW-1:0] b_mem [N][N];

    assign is_idle   = (state == S_IDLE);
    assign busy      = !is_idle;
    assign launch    = is_idle && start;
    assign step_next = launch ? '0 : step + 1'b1;
    // A write landing on the launch edge must already be visible in the t=0 lanes.
    assign fwd_a     = is_idle && wr_en && !wr_sel;
    assign fwd_b     = is_idle && wr_en &&  wr_sel;

    always_ff @(posedge clk) begin
        if (wr_en && is_idle) begin
            if (wr_sel)
                b_mem[wr_row][wr_col] <= wr_data;
            else
                a_mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Lane i carries element k = step - i; the same skew serves A rows and B columns.
    always_comb begin
        int kk;
        w_next = '0;
        d_next = '0;
        kk     = 0;
        for (int i = 0; i < N; i++) begin
            kk = int'(step_next) - i;
            if (kk >= 0 && kk < N) begin
                w_next[i*DW +: DW] = a_mem[AW'(i)][kk[AW-1:0]];
                if (fwd_a && wr_row == AW'(i) && wr_col == kk[AW-1:0])
                    w_next[i*DW +: DW] = wr_data;
                d_next[i*DW +: DW] = b_mem[kk[AW-1:0]][AW'(i)];
                if (fwd_b && wr_row == kk[AW-1:0] && wr_col == AW'(i))
                    d_next[i*DW +: DW] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            step         <= '0;
            compute_en   <= 1'b0;
            weight_out   <= '0;
            data_out     <= '0;
            result_valid <= 1'b0;
            load_err     <= 1'b0;
`ifdef SYSTOLIC_FEEDER_TILE_CNT_EN
            tile_count   <= 8'd0;
`endif
        end else begin
            load_err <= !is_idle && (wr_en || start);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        step       <= '0;
                        compute_en <= 1'b1;
                        weight_out <= w_next;
                        data_out   <= d_next;
                    end
                end
                S_RUN: begin
                    if (step == T_LAST) begin
                        state        <= S_DRAIN;
                        compute_en   <= 1'b0;
                        weight_out   <= '0;
                        data_out     <= '0;
                        result_valid <= 1'b1;
                    end else begin
                        step       <= step_next;
                        weight_out <= w_next;
                        data_out   <= d_next;
                    end
                end
                S_DRAIN: begin
                    state        <= S_IDLE;
                    result_valid <= 1'b0;
`ifdef SYSTOLIC_FEEDER_TILE_CNT_EN
                    tile_count   <= tile_count + 8'd1;
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: scoreboarded lane streams plus a behavioural 4x4 PE grid whose
// accumulators are compared against bench-computed tile products on result_valid.
module tb_systolic_feeder;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int AW = 2;

    logic            clk;
    logic            reset;
    logic            wr_en;
    logic            wr_sel;
    logic [AW-1:0]   wr_row;
    logic [AW-1:0]   wr_col;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic            busy;
    logic            load_err;
    logic            compute_en;
    logic [N*DW-1:0] weight_out;
    logic [N*DW-1:0] data_out;
    logic            result_valid;
`ifdef SYSTOLIC_FEEDER_TILE_CNT_EN
    logic [7:0]      tile_count;
`endif

    systolic_feeder #(.N(N), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .wr_data      (wr_data),
        .start        (start),
        .busy         (busy),
        .load_err     (load_err),
        .compute_en   (compute_en),
        .weight_out   (weight_out),
        .data_out     (data_out),
        .result_valid (result_valid)
`ifdef SYSTOLIC_FEEDER_TILE_CNT_EN
        ,
        .tile_count   (tile_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int cen_cnt = 0;

    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];
    logic [2*N*DW-1:0] lane_q [$];
    logic [8*N*N-1:0]  res_q  [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural PE grid: weights shift right, data shifts down, accumulators clear when idle.
    logic [DW-1:0]   pa  [N][N];
    logic [DW-1:0]   pb  [N][N];
    logic [7:0]      acc [N][N];
    logic            s_cen;
    logic [N*DW-1:0] s_w;
    logic [N*DW-1:0] s_d;

    always @(posedge clk) begin
        logic [DW-1:0] ain;
        logic [DW-1:0] bin;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) ain = s_w[i*DW +: DW];
                else        ain = pa[i][j-1];
                if (i == 0) bin = s_d[j*DW +: DW];
                else        bin = pb[i-1][j];
                pa[i][j]  <= ain;
                pb[i][j]  <= bin;
                acc[i][j] <= s_cen ? 8'(int'(acc[i][j]) + int'(ain) * int'(bin)) : 8'd0;
            end
        end
    end

    always @(negedge clk) begin
        logic [2*N*DW-1:0] e;
        logic [8*N*N-1:0]  r;
        s_cen <= compute_en;
        s_w   <= weight_out;
        s_d   <= data_out;
        if (reset) begin
            lane_q.delete();
            res_q.delete();
            cen_cnt = 0;
        end else begin
            if (compute_en) begin
                cen_cnt++;
                if (lane_q.size() == 0) begin
                    check("lane_extra", 1, 0);
                end else begin
                    e = lane_q.pop_front();
                    check("weight_lanes", weight_out, e[N*DW-1:0]);
                    check("data_lanes", data_out, e[2*N*DW-1:N*DW]);
                end
            end else begin
                check("quiet_lanes", {data_out, weight_out}, 0);
            end
            if (result_valid) begin
                check("rv_busy", busy, 1);
                check("cen_cycles", cen_cnt, 3*N-2);
                cen_cnt = 0;
                if (res_q.size() == 0) begin
                    check("result_extra", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++)
                            check($sformatf("pe_%0d_%0d", i, j), acc[i][j], r[(i*N+j)*8 +: 8]);
                end
                done_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic sel, input int r, input int c, input int d);
        wr_sel  = sel;
        wr_row  = AW'(r);
        wr_col  = AW'(c);
        wr_data = DW'(d);
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        if (sel) mb[r][c] = DW'(d);
        else     ma[r][c] = DW'(d);
    endtask

    task automatic push_expected();
        logic [N*DW-1:0]  w;
        logic [N*DW-1:0]  d;
        logic [8*N*N-1:0] r;
        int s;
        for (int t = 0; t <= 3*N-3; t++) begin
            w = '0;
            d = '0;
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < N) begin
                    w[i*DW +: DW] = ma[i][t-i];
                    d[i*DW +: DW] = mb[t-i][i];
                end
            end
            lane_q.push_back({d, w});
        end
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += int'(ma[i][k]) * int'(mb[k][j]);
                r[(i*N+j)*8 +: 8] = 8'(s);
            end
        end
        res_q.push_back(r);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int c = 0; c < 60 && done_cnt < target; c++) tick();
        check("run_done", done_cnt >= target, 1);
        tick();
    endtask

    int base;

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
        wr_data = '0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) tick();
        check("rst_cen", compute_en, 0);
        check("rst_busy", busy, 0);
        check("rst_rv", result_valid, 0);
        check("rst_lerr", load_err, 0);
        check("rst_w", weight_out, 0);
        check("rst_d", data_out, 0);
`ifdef SYSTOLIC_FEEDER_TILE_CNT_EN
        check("rst_tcnt", tile_count, 0);
`endif

        // Identity weights: results reproduce B.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                write(1'b0, i, k, (i == k) ? 1 : 0);
                write(1'b1, i, k, i*4 + k);
            end
        push_expected();
        pulse_start();
        wait_done(1);

        // Skew pattern.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                write(1'b0, i, k, i*4 + k + 1);
                write(1'b1, i, k, 1);
            end
        push_expected();
        pulse_start();
        check("skew_t0", weight_out, 16'h0001);
        repeat (3) tick();
        check("skew_t3", weight_out, 16'hDA74);
        wait_done(2);

        // Overflow, with A[0][0] written in the same cycle as start.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                write(1'b0, i, k, (i == 0 && k == 0) ? 0 : 15);
                write(1'b1, i, k, 15);
            end
        ma[0][0] = 4'd15;
        push_expected();
        wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 4'd15; wr_en = 1'b1;
        pulse_start();
        wr_en = 1'b0;
        wait_done(3);

        // Dropped write during RUN and dropped start during DRAIN.
        push_expected();
        pulse_start();
        repeat (2) tick();
        wr_sel = 1'b1; wr_row = 2'd1; wr_col = 2'd2; wr_data = 4'd3; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("lerr_wr", load_err, 1);
        tick();
        check("lerr_clr", load_err, 0);
        repeat (6) tick();
        check("in_drain", result_valid, 1);
        pulse_start();
        check("lerr_start", load_err, 1);
        check("idle_busy", busy, 0);
        tick();
        check("no_restart", compute_en, 0);
        push_expected();
        pulse_start();
        wait_done(5);

        // Reset at RUN step 5, then a complete run on the retained tiles.
        push_expected();
        pulse_start();
        repeat (5) tick();
        reset = 1'b1;
        #1;
        check("abort_cen", compute_en, 0);
        check("abort_w", weight_out, 0);
        check("abort_d", data_out, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        base = done_cnt;
        tick();
        push_expected();
        pulse_start();
        wait_done(base + 1);
`ifdef SYSTOLIC_FEEDER_TILE_CNT_EN
        check("tile_count", tile_count, 1);
`endif
        check("lane_q_empty", lane_q.size(), 0);
        check("res_q_empty", res_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
